// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit 7-segment hex driver with scan prescaler,
// frame-aligned double buffering, per-digit decimal points and leading-zero blanking.
module hex_display_scanner #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  busy,
  output logic                  frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    pend_val_q, pend_val_d;
  logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0]    shad_val_q, shad_val_d;
  logic [DIGITS-1:0]      shad_dp_q, shad_dp_d;
  logic                   busy_q, busy_d;
  logic                   frame_q;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [DIGITS-1:0]      an_q, an_d;

  logic                   tick, wrap;
  logic [DIGITS-1:0]      blank;
  logic                   zeros_above;
  logic [3:0]             nib;
  logic [6:0]             glyph;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  assign tick = enable && (cnt_q == CNT_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A load coinciding with the wrap bypasses pending so it is shown this frame.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    shad_val_d = shad_val_q;
    shad_dp_d  = shad_dp_q;
    busy_d     = busy_q;
    if (wrap && load) begin
      shad_val_d = value;
      shad_dp_d  = dp_in;
      busy_d     = 1'b0;
    end else if (wrap && busy_q) begin
      shad_val_d = pend_val_q;
      shad_dp_d  = pend_dp_q;
      busy_d     = 1'b0;
    end else if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
      busy_d     = 1'b1;
    end
  end

  // Blank digit i when lz_blank and nibbles DIGITS-1..i of the shadow are all zero.
  always_comb begin
    blank       = '0;
    zeros_above = lz_blank;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeros_above = zeros_above && (shad_val_q[4*i +: 4] == 4'h0);
      blank[i]    = zeros_above;
    end
  end

  always_comb begin
    nib   = shad_val_q[4*int'(idx_q) +: 4];
    glyph = hex_glyph(nib);
    seg_d = SEG_OFF;
    dp_d  = SEG_ACTIVE_LOW;
    an_d  = AN_OFF;
    if (enable) begin
      seg_d = blank[idx_q] ? SEG_OFF : (SEG_ACTIVE_LOW ? ~glyph : glyph);
      dp_d  = shad_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
      an_d  = AN_ACTIVE_LOW ? ~(DIGITS'(1) << idx_q) : (DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      shad_val_q <= '0;
      shad_dp_q  <= '0;
      busy_q     <= 1'b0;
      frame_q    <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= SEG_ACTIVE_LOW;
      an_q       <= AN_OFF;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      shad_val_q <= shad_val_d;
      shad_dp_q  <= shad_dp_d;
      busy_q     <= busy_d;
      frame_q    <= wrap;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign busy  = busy_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner (4 digits, 4 clks per slot): a scan-position
// model checked every cycle, plus hand-computed literal expectations.
module tb_hex_display_scanner;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clk = 1'b0;
  logic        rst_n, enable, load, lz_blank;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp, busy, frame;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  hex_display_scanner #(.DIGITS(DIGITS), .DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an),
    .busy(busy), .frame(frame)
  );

  always #5 clk = ~clk;

  // Model: scan position derived from the number of enabled cycles since reset.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          m_n = 0;
  logic [15:0] m_pend_val = '0, m_sh_val = '0;
  logic [3:0]  m_pend_dp = '0, m_sh_dp = '0;
  logic        m_busy = 1'b0;
  logic [6:0]  e_seg;
  logic        e_dp, e_frame;
  logic [3:0]  e_an;

  always @(posedge clk) begin
    int  idx;
    logic tick, wrap;
    logic [3:0] nib;
    if (!rst_n) begin
      m_n = 0; m_pend_val = '0; m_pend_dp = '0; m_sh_val = '0; m_sh_dp = '0; m_busy = 1'b0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_frame = 1'b0;
    end else begin
      idx  = (m_n / DIV) % DIGITS;
      tick = enable && (m_n % DIV == DIV - 1);
      wrap = tick && (idx == DIGITS - 1);
      if (enable) begin
        nib   = 4'((m_sh_val >> (4 * idx)) & 16'hF);
        e_an  = ~(4'b0001 << idx);
        e_dp  = ~m_sh_dp[idx];
        e_seg = (lz_blank && idx > 0 && (m_sh_val >> (4 * idx)) == 0) ? 7'h7F : ~glyph[nib];
      end else begin
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
      end
      e_frame = wrap;
      if (wrap && load) begin
        m_sh_val = value; m_sh_dp = dp_in; m_busy = 1'b0;
      end else if (wrap && m_busy) begin
        m_sh_val = m_pend_val; m_sh_dp = m_pend_dp; m_busy = 1'b0;
      end else if (load) begin
        m_pend_val = value; m_pend_dp = dp_in; m_busy = 1'b1;
      end
      if (enable) m_n++;
    end
    #1;
    checks++;
    if (seg !== e_seg) begin errors++; $display("FAIL model_seg t=%0t got %h expected %h", $time, seg, e_seg); end
    checks++;
    if (dp !== e_dp) begin errors++; $display("FAIL model_dp t=%0t got %b expected %b", $time, dp, e_dp); end
    checks++;
    if (an !== e_an) begin errors++; $display("FAIL model_an t=%0t got %h expected %h", $time, an, e_an); end
    checks++;
    if (busy !== m_busy) begin errors++; $display("FAIL model_busy t=%0t got %b expected %b", $time, busy, m_busy); end
    checks++;
    if (frame !== e_frame) begin errors++; $display("FAIL model_frame t=%0t got %b expected %b", $time, frame, e_frame); end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    bit hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (an == target) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL %s timeout waiting an got %h expected %h", name, an, target); end
  endtask

  task automatic wait_frame(input string name);
    bit hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      if (frame) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL %s timeout waiting frame got 0 expected 1", name); end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dp_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int frames;
    rst_n = 1'b0; enable = 1'b1; load = 1'b1; value = 16'hFFFF; dp_in = 4'hF; lz_blank = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_an", an, 4'hF);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame", frame, 1'b0);
    end
    rst_n = 1'b1; load = 1'b0;

    frames = 0;
    repeat (32) begin
      @(negedge clk);
      if (frame) frames++;
    end
    chk("frames_in_32", frames, 2);

    wait_an(4'hB, "load_mid");
    pulse_load(16'h12AF, 4'h0);
    chk("load_busy", busy, 1'b1);
    wait_frame("load_frame");
    chk("load_busy_clear", busy, 1'b0);
    wait_an(4'hE, "load_d0");
    chk("load_d0_seg", seg, 7'h0E);

    wait_an(4'hD, "ovr_mid");
    pulse_load(16'h1111, 4'h0);
    pulse_load(16'h2222, 4'h0);
    wait_frame("ovr_frame");
    wait_an(4'hE, "ovr_d0");
    chk("ovr_d0_seg", seg, 7'h24);

    wait_frame("wrapload_sync");
    repeat (15) @(negedge clk);
    pulse_load(16'h3333, 4'h0);
    chk("wrapload_busy", busy, 1'b0);
    chk("wrapload_frame", frame, 1'b1);
    @(negedge clk);
    chk("wrapload_an", an, 4'hE);
    chk("wrapload_seg", seg, 7'h30);

    lz_blank = 1'b1;
    pulse_load(16'h0050, 4'h0);
    wait_frame("lz_frame");
    wait_an(4'hE, "lz_d0");
    chk("lz_d0_seg", seg, 7'h40);
    wait_an(4'hD, "lz_d1");
    chk("lz_d1_seg", seg, 7'h12);
    wait_an(4'hB, "lz_d2");
    chk("lz_d2_seg", seg, 7'h7F);
    wait_an(4'h7, "lz_d3");
    chk("lz_d3_seg", seg, 7'h7F);
    pulse_load(16'h0000, 4'b1000);
    wait_frame("lz0_frame");
    wait_an(4'hE, "lz0_d0");
    chk("lz0_d0_seg", seg, 7'h40);
    wait_an(4'hD, "lz0_d1");
    chk("lz0_d1_seg", seg, 7'h7F);
    wait_an(4'h7, "lz0_d3");
    chk("lz0_d3_seg", seg, 7'h7F);
    chk("lz0_d3_dp", dp, 1'b0);

    wait_an(4'hB, "en_d2");
    enable = 1'b0;
    @(negedge clk);
    chk("en_off_an", an, 4'hF);
    chk("en_off_seg", seg, 7'h7F);
    repeat (9) @(negedge clk);
    chk("en_hold_an", an, 4'hF);
    enable = 1'b1;
    @(negedge clk);
    chk("en_resume_an", an, 4'hB);

    lz_blank = 1'b0;
    wait_an(4'hD, "rst_mid");
    pulse_load(16'h4444, 4'h0);
    chk("rst_mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy_clr", busy, 1'b0);
    chk("rst_mid_an", an, 4'hF);
    rst_n = 1'b1;
    wait_an(4'hE, "rst_after");
    chk("rst_after_seg", seg, 7'h40);
    wait_an(4'h7, "rst_after_d3");
    chk("rst_after_d3_seg", seg, 7'h40);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexed driver for DIGITS common-anode/cathode 7-segment hex digits; generalises the single-digit segment mapper to N digits.
- Accepts a packed hex value via a load strobe and double-buffers it so the display changes only at a frame boundary.
- Adds a scan prescaler, per-digit decimal points, leading-zero blanking and a global enable.
- Sits between datapath status registers and board display pins.

Parameters:
- DIGITS, 4, number of digits scanned; legal range 1..8.
- DIV, 1000, clk cycles per digit slot; legal range >= 1; DIV=1 gives one slot per clk.
- SEG_ACTIVE_LOW, 1, 1: segment lit = 0; 0: segment lit = 1.
- AN_ACTIVE_LOW, 1, same polarity rule for digit selects.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising clk.
- enable  input  1  1 = scan running; 0 = display dark, counters hold.
- load  input  1  one-cycle strobe; captures value and dp_in.
- value  input  4*DIGITS  packed nibbles; nibble i drives digit i, where digit 0 is least significant.
- dp_in  input  DIGITS  decimal point per digit.
- lz_blank  input  1  1 = suppress leading zeros; sampled live, not buffered.
- seg  output  7  segments: seg[0]=a, seg[1]=b, seg[2]=c, seg[3]=d, seg[4]=e, seg[5]=f, seg[6]=g.
- dp  output  1  decimal point for the digit currently selected.
- an  output  DIGITS  one-hot digit select.
- busy  output  1  1 while a loaded value waits in the pending buffer.
- frame  output  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset (rst_n=0 at an edge) applies regardless of other inputs.
  - Registers cleared: prescaler, digit index, pending, shadow, busy and frame all go to 0.
  - seg, dp and an are driven to their inactive level.
  - With default polarity: seg=7'h7F, dp=1, an=all ones.
  - Reset mid-frame discards any pending value.
- Prescaler: counts 0..DIV-1.
  - tick = enable && count==DIV-1.
  - count wraps to 0 on tick.
  - Held while enable=0.
- Digit index:
  - Advances by 1 on tick; wraps DIGITS-1 -> 0.
  - wrap = tick && index==DIGITS-1.
  - frame is a registered copy of wrap: high exactly 1 cycle, in the cycle after the wrap edge.
- Double buffer:
  - load && !wrap: pending <= {value, dp_in}; busy <= 1.
  - A load while busy=1 overwrites pending (last wins).
  - wrap && busy && !load: shadow <= pending; busy <= 0.
  - wrap && load: shadow <= {value, dp_in} directly; pending is discarded; busy <= 0.
  - While enable=0, no wrap occurs, so pending waits.
  - load is still accepted while enable=0.
- Decode: nibble 0-F maps to standard hex glyphs (active-high abcdefg shown):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Inverted when SEG_ACTIVE_LOW=1.
- Leading-zero blanking: digit i>0 is blank when lz_blank=1 and shadow nibbles DIGITS-1..i are all 0.
  - A blank digit drives seg inactive, but its dp still follows shadow.
  - Digit 0 is never blanked.
- Output timing: seg, dp and an are registered from the current index and shadow.
  - Outputs follow an index change 1 cycle later.
  - When enable=0, outputs go inactive 1 cycle after enable falls.
  - When enable rises, outputs resume on the held index 1 cycle later.
- an is strictly one-hot or all-inactive; never two digits active in the same cycle.
- DIGITS=1: index stays 0; every tick is a wrap.

Test Plan:
- Reset: DIGITS=4, DIV=4, hold rst_n=0 for 3 cycles with load=1 and enable=1 -> seg=7F, dp=1, an=F, busy=0, frame=0 throughout.
- Scan order: after reset, enable=1 -> an cycles E,D,B,7 with each digit active 4 clks; frame pulses once every 16 clks, 1 clk wide.
- Load and tear-free update: load value=16'h12AF mid-frame -> busy=1 until the next wrap; digit 0 then shows 71 (F) active-high, i.e. seg=0E with SEG_ACTIVE_LOW=1; no digit shows the new value before frame.
- Overwrite and simultaneous events:
  - load 16'h1111, then 16'h2222 before the wrap -> shadow=2222.
  - load on the wrap edge -> that value is shown immediately with busy=0.
- Leading zeros: value=16'h0050, lz_blank=1 -> digits 3 and 2 are dark, digit 1 shows 5 and digit 0 shows 0; value=0000 -> only digit 0 is lit, showing 0.
- Enable and reset mid-frame:
  - Drop enable at digit 2 for 10 clks -> an=F and index holds; scanning resumes at digit 2.
  - Assert rst_n=0 while busy=1 -> busy=0 and shadow=0.
